// File: rtl/if_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Package     : arm_pipe_pkg
// Description : Shared types and constants for the fetch/decode boundary.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_pipe_pkg;

  // Datapath width of pc4 and instruction words
  localparam int WORD_W = 32;

  // One buffered fetch result as handed from IF to ID
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction word presented to ID when nothing valid is at the head
  localparam logic [31:0] NOP_INSTR = 32'h0;

  // Occupancy counter width able to represent 0..depth inclusive
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : arm_pipe_pkg
`default_nettype wire

// File: rtl/if_fetch_queue_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ifq_ptr_ctrl
// Description : Read/write pointers, occupancy and handshake qualification
//               for the IF->ID prefetch queue. Macro IFQ_BYPASS_EN lets an
//               entry arriving at an empty queue go straight to ID without
//               being written.
// Revision    : 1.0 - initial release
// ============================================================================
module ifq_ptr_ctrl #(
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1),
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active-low
  input  logic              i_if_valid,
  input  logic              i_id_ready,
  input  logic              i_flush,
  output logic              o_push,
  output logic              o_if_ready,
  output logic              o_id_valid, // stored head valid (count != 0)
  output logic [ADDR_W-1:0] o_wr_ptr,
  output logic [ADDR_W-1:0] o_rd_ptr,
  output logic [CNT_W-1:0]  o_count
);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_bypass;

  // Fullness and emptiness come only from registered occupancy, so if_ready
  // never depends combinationally on id_ready.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

`ifdef IFQ_BYPASS_EN
  // Entry arriving at an empty queue while ID is ready is consumed directly
  assign w_bypass = w_empty & i_if_valid & i_id_ready & ~i_flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign o_push = i_if_valid & ~w_full & ~i_flush & ~w_bypass;
  assign w_pop  = ~w_empty & i_id_ready & ~i_flush;

  // Pointer and occupancy update; flush wins over any push or pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (o_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      r_count <= r_count + CNT_W'(o_push) - CNT_W'(w_pop);
    end
  end

  assign o_if_ready = ~w_full;
  assign o_id_valid = ~w_empty;
  assign o_wr_ptr   = r_wr_ptr;
  assign o_rd_ptr   = r_rd_ptr;
  assign o_count    = r_count;

endmodule : ifq_ptr_ctrl
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_queue
// Description : Instruction prefetch queue between IF and ID. Buffers
//               {pc4, instr} pairs, back-pressures IF when full, flushes in
//               one cycle on a taken branch. Optional macro IFQ_BYPASS_EN
//               adds a combinational pass-through when the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
  parameter int  DEPTH  = 4,
  parameter int  WORD_W = arm_pipe_pkg::WORD_W,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,       // asynchronous, active-low
  input  logic              if_valid,
  input  logic [WORD_W-1:0] if_pc4,
  input  logic [WORD_W-1:0] if_instr,
  output logic              if_ready,
  input  logic              flush,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [WORD_W-1:0] id_pc4,
  output logic [WORD_W-1:0] id_instr,
  output logic [CNT_W-1:0]  count
);

  import arm_pipe_pkg::*;

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WORD_W-1:0] r_mem_pc4   [DEPTH];
  logic [WORD_W-1:0] r_mem_instr [DEPTH];
  logic              w_push;
  logic              w_stored_valid;
  logic [ADDR_W-1:0] w_wr_ptr;
  logic [ADDR_W-1:0] w_rd_ptr;

  ifq_ptr_ctrl #(
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W),
    .ADDR_W (ADDR_W)
  ) u_ptr_ctrl (
    .clk        (clk),
    .rst        (rst),
    .i_if_valid (if_valid),
    .i_id_ready (id_ready),
    .i_flush    (flush),
    .o_push     (w_push),
    .o_if_ready (if_ready),
    .o_id_valid (w_stored_valid),
    .o_wr_ptr   (w_wr_ptr),
    .o_rd_ptr   (w_rd_ptr),
    .o_count    (count)
  );

  // Entry storage; left unreset because every read is gated by occupancy
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc4[w_wr_ptr]   <= if_pc4;
      r_mem_instr[w_wr_ptr] <= if_instr;
    end
  end

  // Head presentation to ID: stored entry first, else optional pass-through
  always_comb begin
    id_valid = 1'b0;
    id_pc4   = '0;
    id_instr = WORD_W'(NOP_INSTR);
    if (w_stored_valid) begin
      id_valid = 1'b1;
      id_pc4   = r_mem_pc4[w_rd_ptr];
      id_instr = r_mem_instr[w_rd_ptr];
    end
`ifdef IFQ_BYPASS_EN
    else if (!flush && if_valid) begin
      id_valid = 1'b1;
      id_pc4   = if_pc4;
      id_instr = if_instr;
    end
`endif
  end

endmodule : if_fetch_queue
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_queue
// Description : Self-checking bench for if_fetch_queue (DEPTH=4). A FIFO
//               queue model predicts every output each cycle; directed
//               scenarios are followed by a randomized phase. Honours
//               IFQ_BYPASS_EN when the design is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;
  import arm_pipe_pkg::*;

  localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc4;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        flush;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc4;
  logic [31:0] id_instr;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  fetch_entry_t q[$];     // reference contents, head at index 0
  logic [31:0]  seen[$];  // pc4 values ID actually consumed

  if_fetch_queue #(.DEPTH(DEPTH), .WORD_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_pc4   (if_pc4),
    .if_instr (if_instr),
    .if_ready (if_ready),
    .flush    (flush),
    .id_ready (id_ready),
    .id_valid (id_valid),
    .id_pc4   (id_pc4),
    .id_instr (id_instr),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, compare against model, clock, advance model
  task automatic step(input logic v, input logic [31:0] pc4, input logic [31:0] ins,
                      input logic rdy, input logic fl);
    int          sz;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_in;
    bit          take_direct;
    bit          do_pop;
    bit          do_push;
    if_valid = v; if_pc4 = pc4; if_instr = ins; id_ready = rdy; flush = fl;
    #1;
    sz   = q.size();
    e_v  = 1'b0; e_pc = '0; e_in = '0;
    if (sz > 0) begin
      e_v = 1'b1; e_pc = q[0].pc4; e_in = q[0].instr;
    end else if (BYP && !fl && v) begin
      e_v = 1'b1; e_pc = pc4; e_in = ins;
    end
    chk("count",    64'(count),    64'(sz));
    chk("if_ready", 64'(if_ready), 64'(sz != DEPTH));
    chk("id_valid", 64'(id_valid), 64'(e_v));
    chk("id_pc4",   64'(id_pc4),   64'(e_pc));
    chk("id_instr", 64'(id_instr), 64'(e_in));
    if (id_valid && rdy && !fl) seen.push_back(id_pc4);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      take_direct = BYP && (sz == 0) && v && rdy;
      do_pop      = (sz > 0) && rdy;
      do_push     = v && (sz < DEPTH) && !take_direct;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back({pc4, ins});
    end
    #1;
  endtask

  task automatic chk_seen(input string tag, input logic [31:0] first, input int n);
    chk({tag, "_len"}, 64'(seen.size()), 64'(n));
    for (int i = 0; i < n && i < seen.size(); i++)
      chk({tag, "_order"}, 64'(seen[i]), 64'(first + 32'(4 * i)));
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_pc4 = '0; if_instr = '0;
    id_ready = 1'b0; flush = 1'b0;

    // 1. asynchronous reset
    #2 rst = 1'b0;
    #1;
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_count",    64'(count),    64'd0);
    chk("rst_if_ready", 64'(if_ready), 64'd1);
    chk("rst_id_instr", 64'(id_instr), 64'd0);
    #4 rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_count",    64'(count),    64'd0);
    chk("post_rst_id_valid", 64'(id_valid), 64'd0);

    // 2. fill three with ID frozen, then drain in order
    step(1, 32'd4,  32'hE3A01001, 0, 0);
    step(1, 32'd8,  32'hE3A01002, 0, 0);
    step(1, 32'd12, 32'hE3A01003, 0, 0);
    chk("t2_count3", 64'(count), 64'd3);
    seen.delete();
    for (int i = 0; i < 4; i++) step(0, '0, '0, 1, 0);
    chk_seen("t2", 32'd4, 3);
    chk("t2_count0", 64'(count), 64'd0);

    // 3. fill to full, overflow attempt, single pop
    for (int i = 0; i < 4; i++) step(1, 32'd100 + 32'(4 * i), 32'hA0 + 32'(i), 0, 0);
    chk("t3_full_count", 64'(count),    64'd4);
    chk("t3_full_ready", 64'(if_ready), 64'd0);
    step(1, 32'h200, 32'hDEAD, 0, 0);
    chk("t3_no_overflow", 64'(count), 64'd4);
    seen.delete();
    step(1, 32'h204, 32'hBEEF, 1, 0);
    chk("t3_pop_count", 64'(count),    64'd3);
    chk("t3_pop_ready", 64'(if_ready), 64'd1);
    for (int i = 0; i < 3; i++) step(0, '0, '0, 1, 0);
    chk_seen("t3", 32'd100, 4);

    // 4. flush with a same-cycle push
    step(1, 32'd300, 32'h1, 0, 0);
    step(1, 32'd304, 32'h2, 0, 0);
    chk("t4_count2", 64'(count), 64'd2);
    seen.delete();
    step(1, 32'd16, 32'h3, 0, 1);
    chk("t4_flush_count", 64'(count),    64'd0);
    chk("t4_flush_valid", 64'(id_valid), 64'd0);
    for (int i = 0; i < 3; i++) step(0, '0, '0, 1, 0);
    chk("t4_nothing_seen", 64'(seen.size()), 64'd0);

    // 5. streaming with pointer wrap
    seen.delete();
    for (int i = 1; i <= 10; i++) begin
      step(1, 32'(4 * i), 32'hC0 + 32'(i), 1, 0);
      chk("t5_count_le1", 64'(count <= 3'd1), 64'd1);
    end
    step(0, '0, '0, 1, 0);
    chk_seen("t5", 32'd4, 10);

    // 6. push into empty queue with ID ready
    step(1, 32'd20, 32'hE3A0F014, 1, 0);
    chk("t6_count", 64'(count), BYP ? 64'd0 : 64'd1);
    step(0, '0, '0, 1, 0);

    // mid-operation asynchronous reset loses everything
    step(1, 32'd500, 32'h5, 0, 0);
    step(1, 32'd504, 32'h6, 0, 0);
    if_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst_count", 64'(count),    64'd0);
    chk("midrst_valid", 64'(id_valid), 64'd0);
    #1 rst = 1'b1;
    q.delete();
    @(posedge clk); #1;

    // randomized traffic against the model
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 11) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_if_fetch_queue
`default_nettype wire
